// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register file + 8-op ALU with a one-cycle registered write-back stage.
//
// Two combinational read ports feed the ALU. On an issue edge the selected value
// (ALU result or d_in) is captured into the WB stage and mirrored on alu_out.
// On the following edge the WB stage commits into the register file. Reads that
// hit the pending WB address are bypassed from the WB stage.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   valid_in            operation issued this cycle
//   sel                 WB source: 0 = d_in, 1 = ALU result
//   wr                  commit WB data to wr_addr
//   op                  ALU opcode
//   rd_addr_a/b         read port addresses
//   wr_addr             write-back address
//   d_in                external write data
//   d_out_a/b           bypassed read data (combinational)
//   alu_out             registered WB data
//   valid_out           alu_out valid, one cycle after valid_in
//   cout, zero          registered flags from the last sel=1 operation
module reg_alu_pipe #(
  parameter int W       = 8,
  parameter int NREGS   = 8,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic          sel,
  input  logic          wr,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  d_in,
  output logic [W-1:0]  d_out_a,
  output logic [W-1:0]  d_out_b,
  output logic [W-1:0]  alu_out,
  output logic          valid_out,
  output logic          cout,
  output logic          zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  localparam int unsigned NR = NREGS;

  logic [W-1:0]  rf [NREGS];

  logic          wb_v;
  logic          wb_wr;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;

  logic          wb_hit_a;
  logic          wb_hit_b;
  logic [W:0]    sum;
  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic [W-1:0]  wb_next;
  logic          commit;

  // Read ports: newest value comes from the pending WB stage; r0 is forced to
  // zero after the bypass so a pending r0 write never leaks through.
  always_comb begin
    wb_hit_a = wb_v && wb_wr && (wb_addr == rd_addr_a);
    wb_hit_b = wb_v && wb_wr && (wb_addr == rd_addr_b);
    d_out_a  = wb_hit_a ? wb_data : rf[rd_addr_a];
    d_out_b  = wb_hit_b ? wb_data : rf[rd_addr_b];
    if ((ZERO_R0 != 0) && (rd_addr_a == '0)) d_out_a = '0;
    if ((ZERO_R0 != 0) && (rd_addr_b == '0)) d_out_b = '0;
  end

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        sum     = {1'b0, d_out_a} + {1'b0, d_out_b};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is set exactly when A >= B (no borrow).
        sum     = {1'b0, d_out_a} + {1'b0, ~d_out_b} + {{W{1'b0}}, 1'b1};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
      end
      OP_AND:  alu_res = d_out_a & d_out_b;
      OP_OR:   alu_res = d_out_a | d_out_b;
      OP_XOR:  alu_res = d_out_a ^ d_out_b;
      OP_SHL: begin
        alu_res = {d_out_a[W-2:0], 1'b0};
        alu_c   = d_out_a[W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, d_out_a[W-1:1]};
        alu_c   = d_out_a[0];
      end
      OP_PASS: alu_res = d_out_a;
      default: alu_res = d_out_a;
    endcase
  end

  always_comb begin
    wb_next = sel ? alu_res : d_in;
    commit  = wb_v && wb_wr && !((ZERO_R0 != 0) && (wb_addr == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NR; i++) rf[i] <= '0;
      wb_v      <= 1'b0;
      wb_wr     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      alu_out   <= '0;
      valid_out <= 1'b0;
      cout      <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (commit) rf[wb_addr] <= wb_data;
      wb_v      <= valid_in;
      valid_out <= valid_in;
      if (valid_in) begin
        wb_wr   <= wr;
        wb_addr <= wr_addr;
        wb_data <= wb_next;
        alu_out <= wb_next;
        if (sel) begin
          cout <= alu_c;
          zero <= (alu_res == '0);
        end
      end
    end
  end

endmodule
